fpu: RTL and testbench

Single-precision (IEEE-754 binary32) floating-point arithmetic unit performing addition, subtraction and multiplication on two 32-bit operands. Opcode-selected, with one registered result per clock. It sits in the datapath as a leaf compute block. Surrounding logic drives operands and opcode, and samples the result one clock later.

---
 rtl/fpu.sv | 176 +++++++++++++++++
 tb/tb_fpu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu.sv
// fpu: binary32 add / subtract / multiply with a single registered result.
// Round-to-nearest-even throughout. Subnormal inputs are read as signed zero,
// and results that are tiny after rounding are flushed to signed zero.
`timescale 1ns/1ps
module fpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  opcode,
  output logic [31:0] out
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp_t;

  localparam logic [31:0] QNAN   = 32'h7FC0_0000;
  localparam logic [1:0]  OP_ADD = 2'b00;
  localparam logic [1:0]  OP_SUB = 2'b01;
  localparam logic [1:0]  OP_MUL = 2'b10;

  // Leading-zero count over the 27-bit aligned sum (27 when the value is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  // Round a normalized 24-bit mantissa (hidden bit at [23]) with guard and
  // round|sticky, renormalize on carry-out, then saturate to Inf or flush to 0.
  function automatic logic [31:0] round_pack(
    input logic              sign,
    input logic signed [9:0] exp,
    input logic [23:0]       mant,
    input logic              g,
    input logic              rs
  );
    logic [24:0]       m;
    logic signed [9:0] e;
    m = {1'b0, mant} + {24'd0, g & (rs | mant[0])};
    e = exp;
    if (m[24]) begin
      m = m >> 1;
      e = exp + 10'sd1;
    end
    if (e >= 10'sd255)    round_pack = {sign, 8'hFF, 23'd0};
    else if (e <= 10'sd0) round_pack = {sign, 31'd0};
    else                  round_pack = {sign, e[7:0], m[22:0]};
  endfunction

  fp_t  fa, fb;
  logic sb_eff;
  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  assign fa     = a;
  assign fb     = b;
  assign sb_eff = fb.sign ^ (opcode == OP_SUB);

  assign a_zero = (fa.exp == 8'd0);
  assign a_inf  = (fa.exp == 8'hFF) && (fa.frac == 23'd0);
  assign a_nan  = (fa.exp == 8'hFF) && (fa.frac != 23'd0);
  assign b_zero = (fb.exp == 8'd0);
  assign b_inf  = (fb.exp == 8'hFF) && (fb.frac == 23'd0);
  assign b_nan  = (fb.exp == 8'hFF) && (fb.frac != 23'd0);

  // ---------------- add / subtract datapath (finite nonzero operands) ------
  logic              a_ge_b, sign_l, eff_sub;
  logic [7:0]        exp_l, exp_s, shamt;
  logic [26:0]       l_ext, s_ext, s_al, nrm;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic [31:0]       add_res;

  // Order by magnitude, align the smaller operand with G/R/S kept, add or
  // subtract, normalize, and round. Larger-magnitude operand sets the sign.
  always_comb begin
    a_ge_b = {fa.exp, fa.frac} >= {fb.exp, fb.frac};
    if (a_ge_b) begin
      sign_l = fa.sign;
      exp_l  = fa.exp;
      exp_s  = fb.exp;
      l_ext  = {1'b1, fa.frac, 3'b000};
      s_ext  = {1'b1, fb.frac, 3'b000};
    end else begin
      sign_l = sb_eff;
      exp_l  = fb.exp;
      exp_s  = fa.exp;
      l_ext  = {1'b1, fb.frac, 3'b000};
      s_ext  = {1'b1, fa.frac, 3'b000};
    end
    eff_sub = fa.sign ^ sb_eff;
    shamt   = exp_l - exp_s;

    // A shift of 26+ leaves nothing but a nonzero sticky bit.
    if (shamt >= 8'd26)
      s_al = 27'd1;
    else
      s_al = (s_ext >> shamt) |
             {26'd0, |(s_ext & ((27'd1 << shamt) - 27'd1))};

    sum = eff_sub ? ({1'b0, l_ext} - {1'b0, s_al})
                  : ({1'b0, l_ext} + {1'b0, s_al});
    lz  = lzc27(sum[26:0]);

    if (sum[27]) begin
      nrm   = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, exp_l}) + 10'sd1;
    end else begin
      nrm   = sum[26:0] << lz;
      exp_n = $signed({2'b00, exp_l}) - $signed({5'b00000, lz});
    end

    // Exact cancellation always gives +0.
    if (sum == 28'd0)
      add_res = 32'h0000_0000;
    else
      add_res = round_pack(sign_l, exp_n, nrm[26:3], nrm[2], nrm[1] | nrm[0]);
  end

  // ---------------- multiply datapath (finite nonzero operands) ------------
  logic [47:0]       prod;
  logic              sign_m;
  logic signed [9:0] exp_m;
  logic [31:0]       mul_res;

  // 24x24 product normalizes by at most one bit before rounding.
  always_comb begin
    prod   = {24'd0, 1'b1, fa.frac} * {24'd0, 1'b1, fb.frac};
    sign_m = fa.sign ^ fb.sign;
    exp_m  = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127;
    if (prod[47])
      mul_res = round_pack(sign_m, exp_m + 10'sd1, prod[47:24], prod[23], |prod[22:0]);
    else
      mul_res = round_pack(sign_m, exp_m, prod[46:23], prod[22], |prod[21:0]);
  end

  // ---------------- special-value resolution and opcode select -------------
  logic [31:0] res;

  // NaN beats invalid ops, which beat Inf, then zero operands, then datapath.
  always_comb begin
    res = 32'h0000_0000;
    case (opcode)
      OP_ADD, OP_SUB: begin
        if (a_nan || b_nan)                         res = QNAN;
        else if (a_inf && b_inf && fa.sign != sb_eff) res = QNAN;
        else if (a_inf)                             res = {fa.sign, 8'hFF, 23'd0};
        else if (b_inf)                             res = {sb_eff, 8'hFF, 23'd0};
        else if (a_zero && b_zero)                  res = {fa.sign & sb_eff, 31'd0};
        else if (a_zero)                            res = {sb_eff, b[30:0]};
        else if (b_zero)                            res = a;
        else                                        res = add_res;
      end
      OP_MUL: begin
        if (a_nan || b_nan)                           res = QNAN;
        else if ((a_inf && b_zero) || (b_inf && a_zero)) res = QNAN;
        else if (a_inf || b_inf)                      res = {sign_m, 8'hFF, 23'd0};
        else if (a_zero || b_zero)                    res = {sign_m, 31'd0};
        else                                          res = mul_res;
      end
      default: res = 32'h0000_0000;
    endcase
  end

  // Result register; reset clears it immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 32'h0000_0000;
    else     out <= res;
  end

endmodule

// File: tb/tb_fpu.sv
// tb_fpu: directed and randomized checks of fpu against a real-arithmetic
// float32 reference (round-to-nearest-even, flush-to-zero).
`timescale 1ns/1ps
module tb_fpu;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [1:0]  opcode = '0;
  logic [31:0] out;

  int errors = 0;
  int checks = 0;

  fpu dut (.clk(clk), .rst(rst), .a(a), .b(b), .opcode(opcode), .out(out));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'd0;
  endfunction

  // Exact value of a float32 as a double (subnormals read as signed zero).
  function automatic real to_real(input logic [31:0] x);
    if (x[30:23] == 8'd0) return $bitstoreal({x[31], 63'd0});
    return $bitstoreal({x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0});
  endfunction

  // Round a double to float32, RNE, overflow to Inf, tiny results to zero.
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    logic [24:0] m;
    logic [28:0] rem;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e   = int'(d[62:52]) - 1023 + 127;
    m   = {2'b01, d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {d[63], 31'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] op);
    logic [31:0] yy;
    int          ex, ey;
    if (op == 2'b11) return 32'h0;
    yy = y;
    if (op == 2'b01) yy[31] = ~yy[31];
    if (is_nan(x) || is_nan(yy)) return QNAN;
    if (op == 2'b10) begin
      if ((is_inf(x) && is_zero(yy)) || (is_inf(yy) && is_zero(x))) return QNAN;
      if (is_inf(x) || is_inf(yy)) return {x[31] ^ yy[31], 8'hFF, 23'd0};
      return to_f32(to_real(x) * to_real(yy));
    end
    if (is_inf(x) && is_inf(yy) && x[31] != yy[31]) return QNAN;
    if (is_inf(x))  return x;
    if (is_inf(yy)) return yy;
    // Past 28 binades the smaller operand is below half an ulp of the larger,
    // and a double would no longer hold the exact sum.
    if (!is_zero(x) && !is_zero(yy)) begin
      ex = int'(x[30:23]);
      ey = int'(yy[30:23]);
      if (ex > ey + 28) return x;
      if (ey > ex + 28) return yy;
    end
    return to_f32(to_real(x) + to_real(yy));
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic int clampe(input int e);
    if (e < 1)   return 1;
    if (e > 254) return 254;
    return e;
  endfunction

  function automatic logic [31:0] rnd_norm();
    return {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_special();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return 32'h7FC0_1234;
      default: return {1'($urandom), 8'd0, 23'($urandom)};
    endcase
  endfunction

  // Operand b for add/sub, biased toward close exponents and cancellation.
  function automatic logic [31:0] rnd_addend(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    case ($urandom_range(0, 3))
      0: return rnd_norm();
      1: return {1'($urandom), 8'(clampe(e + int'($urandom_range(0, 8)) - 4)), 23'($urandom)};
      2: return {1'($urandom), x[30:0] ^ 31'($urandom_range(0, 255))};
      default: return {1'($urandom),
                       8'(clampe(e + ($urandom_range(0, 1) == 0 ? 1 : -1) *
                                 int'($urandom_range(20, 40)))),
                       23'($urandom)};
    endcase
  endfunction

  // Operand b for mul, biased toward the underflow and overflow edges.
  function automatic logic [31:0] rnd_factor(input logic [31:0] x);
    int e, tgt;
    e = int'(x[30:23]);
    case ($urandom_range(0, 2))
      0: return rnd_norm();
      1: tgt = 127;
      default: tgt = 381;
    endcase
    return {1'($urandom), 8'(clampe(tgt - e + int'($urandom_range(0, 4)) - 2)), 23'($urandom)};
  endfunction

  task automatic check(input string tag, input logic [31:0] expv);
    checks++;
    assert (out === expv) else begin
      errors++;
      $error("FAIL %s: out=%h expected=%h (a=%h b=%h op=%0d)", tag, out, expv, a, b, opcode);
    end
  endtask

  // Apply one operation, capture on the next edge, check just after it.
  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                      input string tag, input logic [31:0] expv);
    a = x; b = y; opcode = op;
    @(posedge clk);
    #1;
    check(tag, expv);
  endtask

  task automatic step_m(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                        input string tag);
    step(x, y, op, tag, model(x, y, op));
  endtask

  // Safety net so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: out=%h expected=finish", out);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x, y;

    // Reset before any clock edge, and held across one.
    #3;
    check("reset_async", 32'h0);
    @(posedge clk); #1;
    check("reset_hold", 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    step(32'h3F80_0000, 32'h4000_0000, 2'b00, "add_1p2",       32'h4040_0000);
    step(32'h3F80_0000, 32'h3F80_0000, 2'b01, "sub_equal",     32'h0000_0000);
    step(32'h4040_0000, 32'h4080_0000, 2'b10, "mul_3x4",       32'h4140_0000);
    step(32'h7F7F_FFFF, 32'h4000_0000, 2'b10, "mul_overflow",  32'h7F80_0000);
    step(32'h3F80_0000, 32'h3380_0000, 2'b00, "tie_even_down", 32'h3F80_0000);
    step(32'h3F80_0001, 32'h3380_0000, 2'b00, "tie_even_up",   32'h3F80_0002);
    step(32'h7F80_0000, 32'hFF80_0000, 2'b00, "inf_minus_inf", 32'h7FC0_0000);
    step(32'h7F80_0000, 32'h0000_0000, 2'b10, "inf_times_0",   32'h7FC0_0000);
    step(32'h7FC0_0000, 32'h3F80_0000, 2'b00, "nan_in",        32'h7FC0_0000);
    step(32'h8000_0000, 32'h8000_0000, 2'b00, "negz_plus_negz", 32'h8000_0000);
    step(32'h4040_0000, 32'h4080_0000, 2'b11, "reserved_op",   32'h0000_0000);
    step(32'h0000_0001, 32'h3F80_0000, 2'b10, "subnorm_mul",   32'h0000_0000);
    step(32'h0080_0000, 32'h3F00_0000, 2'b10, "mul_ftz",       32'h0000_0000);
    step(32'hC000_0000, 32'h0000_0000, 2'b00, "add_zero_b",    32'hC000_0000);
    step(32'h0000_0000, 32'h4000_0000, 2'b01, "sub_zero_a",    32'hC000_0000);
    step(32'h3F80_0000, 32'h3F7F_FFFF, 2'b01, "sub_cancel",    32'h3380_0000);
    step(32'h4040_0000, 32'hFF80_0000, 2'b10, "mul_neg_inf",   32'hFF80_0000);

    // Asynchronous reset mid-stream while out holds 1+2.
    step(32'h3F80_0000, 32'h4000_0000, 2'b00, "pre_reset", 32'h4040_0000);
    #2 rst = 1'b1;
    #1 check("rst_mid_async", 32'h0);
    @(posedge clk); #1;
    check("rst_mid_hold", 32'h0);
    #2 rst = 1'b0;
    #1 check("rst_release_wait", 32'h0);
    @(posedge clk); #1;
    check("rst_release_load", 32'h4040_0000);

    // Alternating ADD/SUB every cycle on random operands.
    for (int i = 0; i < 12000; i++) begin
      x = ($urandom_range(0, 31) == 0) ? rnd_special() : rnd_norm();
      y = ($urandom_range(0, 31) == 0) ? rnd_special() : rnd_addend(x);
      step_m(x, y, (i % 2 == 0) ? 2'b00 : 2'b01, "addsub_rand");
    end

    // Random multiplies, leaning on the exponent edges.
    for (int i = 0; i < 6000; i++) begin
      x = ($urandom_range(0, 31) == 0) ? rnd_special() : rnd_norm();
      y = ($urandom_range(0, 31) == 0) ? rnd_special() : rnd_factor(x);
      step_m(x, y, 2'b10, "mul_rand");
    end

    // Random opcode switching each cycle, including the reserved code.
    for (int i = 0; i < 1000; i++) begin
      x = rnd_norm();
      y = rnd_addend(x);
      step_m(x, y, 2'($urandom_range(0, 3)), "mixed_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
